// File: rtl/ledger_pkg.sv
// ledger_pkg: shared state type, record byte map and field-reorder helpers
// for the ledger RAM port controller.
//   state_t                - controller FSM states
//   RECORD_BYTES, OFF_*    - RAM byte offsets of each ledger field
//   result_to_bytes        - datapath result word -> RAM byte order
//   bytes_to_memory_values - RAM byte order -> packed memory_values word
package ledger_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, LOAD_DRAIN, STORE, FINISH} state_t;

    localparam int RECORD_BYTES = 6;
    localparam int OFF_P1_PRIV  = 0;
    localparam int OFF_P1_PUB   = 1;
    localparam int OFF_P1_AMT   = 2;
    localparam int OFF_P2_PRIV  = 3;
    localparam int OFF_P2_PUB   = 4;
    localparam int OFF_P2_AMT   = 5;

    typedef logic [RECORD_BYTES-1:0][7:0] rec_bytes_t;

    // result word is {p1_amt,p1_pub,p1_priv,p2_amt,p2_pub,p2_priv}
    function automatic rec_bytes_t result_to_bytes(input logic [47:0] r);
        rec_bytes_t b;
        b[OFF_P1_AMT]  = r[47:40];
        b[OFF_P1_PUB]  = r[39:32];
        b[OFF_P1_PRIV] = r[31:24];
        b[OFF_P2_AMT]  = r[23:16];
        b[OFF_P2_PUB]  = r[15:8];
        b[OFF_P2_PRIV] = r[7:0];
        return b;
    endfunction

    // memory_values is {p1_priv,p1_pub,p1_amt,p2_priv,p2_pub,p2_amt}
    function automatic logic [47:0] bytes_to_memory_values(input rec_bytes_t b);
        return {b[OFF_P1_PRIV], b[OFF_P1_PUB], b[OFF_P1_AMT],
                b[OFF_P2_PRIV], b[OFF_P2_PUB], b[OFF_P2_AMT]};
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// rd_valid_pipe: DEPTH-stage shift register of {valid, byte index} that
// tracks each issued RAM read until its data is present on ram_q.
//   clock, resetn        - clock, synchronous active-low reset
//   in_valid, in_idx     - read issued this cycle and its byte index
//   out_valid, out_idx   - ram_q holds byte out_idx this cycle
module rd_valid_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 3
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][IDX_W-1:0] ix;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            v  <= '0;
            ix <= '0;
        end else begin
            v[0]  <= in_valid;
            ix[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                v[i]  <= v[i-1];
                ix[i] <= ix[i-1];
            end
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_idx   = ix[DEPTH-1];

endmodule

// File: rtl/ledger_mem_ctrl.sv
// ledger_mem_ctrl: byte-wide RAM port controller for the two-player coin
// ledger; loads a six-byte record into memory_values and stores the
// datapath result word back as six bytes.
//   clock, resetn              - clock, synchronous active-low reset
//   load_req, store_req        - operation requests, sampled in IDLE
//   record_in                  - result word to store
//   memory_values              - last loaded/stored record (packed)
//   load_register, store_done  - one-cycle completion strobes
//   busy                       - controller not in IDLE
//   ram_address, ram_data,
//   ram_wren, ram_q            - RAM port
module ledger_mem_ctrl
    import ledger_pkg::*;
#(
    parameter int ADDR_W       = 5,
    parameter int BASE_ADDR    = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load_req,
    input  logic              store_req,
    input  logic [47:0]       record_in,
    output logic [47:0]       memory_values,
    output logic              load_register,
    output logic              busy,
    output logic              store_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    input  logic [7:0]        ram_q
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [2:0]        LAST = 3'(RECORD_BYTES - 1);

    state_t     state, state_next;
    logic [2:0] cnt, cnt_inc, pipe_idx;
    logic       is_store, load_full, pipe_valid;
    rec_bytes_t in_bytes, wbytes, shadow;

    assign cnt_inc  = cnt + 3'd1;
    assign in_bytes = result_to_bytes(record_in);

    // cnt is the beat index whose address is on the bus during LOAD
    rd_valid_pipe #(.DEPTH(READ_LATENCY), .IDX_W(3)) u_pipe (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (state == LOAD),
        .in_idx    (cnt),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx)
    );

    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       state_next = store_req ? STORE : (load_req ? LOAD : IDLE);
            LOAD:       state_next = (cnt == LAST) ? LOAD_DRAIN : LOAD;
            LOAD_DRAIN: state_next = load_full ? FINISH : LOAD_DRAIN;
            STORE:      state_next = (cnt == LAST) ? FINISH : STORE;
            FINISH:     state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = state != IDLE;
        ram_wren      = state == STORE;
        load_register = (state == FINISH) && !is_store;
        store_done    = (state == FINISH) && is_store;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt           <= '0;
            is_store      <= 1'b0;
            load_full     <= 1'b0;
            wbytes        <= '0;
            shadow        <= '0;
            memory_values <= '0;
            ram_address   <= '0;
            ram_data      <= '0;
        end else begin
            if (pipe_valid) shadow[pipe_idx] <= ram_q;
            // set once the last byte is in shadow; memory_values follows one edge later
            load_full <= (state == IDLE) ? 1'b0 : (load_full | (pipe_valid && pipe_idx == LAST));
            case (state)
                IDLE: begin
                    if (store_req) begin
                        is_store    <= 1'b1;
                        cnt         <= '0;
                        wbytes      <= in_bytes;
                        ram_address <= BASE;
                        ram_data    <= in_bytes[0];
                    end else if (load_req) begin
                        is_store    <= 1'b0;
                        cnt         <= '0;
                        ram_address <= BASE;
                    end
                end
                LOAD: begin
                    if (cnt != LAST) begin
                        cnt         <= cnt_inc;
                        ram_address <= BASE + ADDR_W'(cnt_inc);
                    end
                end
                LOAD_DRAIN: begin
                    if (load_full) memory_values <= bytes_to_memory_values(shadow);
                end
                STORE: begin
                    if (cnt != LAST) begin
                        cnt         <= cnt_inc;
                        ram_address <= BASE + ADDR_W'(cnt_inc);
                        ram_data    <= wbytes[cnt_inc];
                    end else begin
                        memory_values <= bytes_to_memory_values(wbytes);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ledger_mem_ctrl.sv
// tb_ledger_mem_ctrl: scoreboard bench for ledger_mem_ctrl with two instances,
// one at default parameters and one with a wrapping base and two-cycle RAM.
module tb_ledger_mem_ctrl;

    typedef struct packed {logic [4:0] a; logic [7:0] d;} wr_t;
    typedef struct packed {logic st; logic [47:0] mv;} ev_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ld_a, st_a, ld_b, st_b;
    logic [47:0] rec;
    logic [47:0] mv_a, mv_b, mv_s;
    logic        lr_a, lr_b, lr_s, sd_a, sd_b, sd_s, busy_a, busy_b, busy_s, wren_a, wren_b;
    logic [4:0]  addr_a, addr_b, pre_addr;
    logic [7:0]  data_a, data_b, q_a, q_b, q1_b, pre_data;
    logic        pre_a, pre_b, sel;
    logic [7:0]  mem_a [32];
    logic [7:0]  mem_b [32];
    logic [7:0]  ref_a [32];
    logic [7:0]  ref_b [32];
    wr_t         wq_a[$], wq_b[$];
    ev_t         eq_a[$], eq_b[$];
    wr_t         wa, wb;
    ev_t         ea, eb;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign lr_s   = sel ? lr_b : lr_a;
    assign sd_s   = sel ? sd_b : sd_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign mv_s   = sel ? mv_b : mv_a;

    ledger_mem_ctrl u_a (
        .clock(clk), .resetn(resetn), .load_req(ld_a), .store_req(st_a), .record_in(rec),
        .memory_values(mv_a), .load_register(lr_a), .busy(busy_a), .store_done(sd_a),
        .ram_address(addr_a), .ram_data(data_a), .ram_wren(wren_a), .ram_q(q_a)
    );

    ledger_mem_ctrl #(.ADDR_W(5), .BASE_ADDR(30), .READ_LATENCY(2)) u_b (
        .clock(clk), .resetn(resetn), .load_req(ld_b), .store_req(st_b), .record_in(rec),
        .memory_values(mv_b), .load_register(lr_b), .busy(busy_b), .store_done(sd_b),
        .ram_address(addr_b), .ram_data(data_b), .ram_wren(wren_b), .ram_q(q_b)
    );

    always @(posedge clk) begin
        if (pre_a) mem_a[pre_addr] <= pre_data;
        else if (wren_a) mem_a[addr_a] <= data_a;
        if (pre_b) mem_b[pre_addr] <= pre_data;
        else if (wren_b) mem_b[addr_b] <= data_b;
        q_a  <= mem_a[addr_a];
        q1_b <= mem_b[addr_b];
        q_b  <= q1_b;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tb_byte(input logic [47:0] r, input int k);
        case (k)
            0:       return r[31:24];
            1:       return r[39:32];
            2:       return r[47:40];
            3:       return r[7:0];
            4:       return r[15:8];
            default: return r[23:16];
        endcase
    endfunction

    task automatic push_store(input bit b, input logic [47:0] r);
        ev_t e;
        wr_t w;
        e.st = 1'b1;
        e.mv = '0;
        for (int k = 0; k < 6; k++) begin
            w.a  = b ? 5'(30 + k) : 5'(k);
            w.d  = tb_byte(r, k);
            e.mv = {e.mv[39:0], w.d};
            if (b) wq_b.push_back(w); else wq_a.push_back(w);
        end
        if (b) eq_b.push_back(e); else eq_a.push_back(e);
    endtask

    task automatic push_load(input bit b);
        ev_t e;
        e.st = 1'b0;
        e.mv = '0;
        for (int k = 0; k < 6; k++)
            e.mv = {e.mv[39:0], b ? ref_b[5'(30 + k)] : ref_a[5'(k)]};
        if (b) eq_b.push_back(e); else eq_a.push_back(e);
    endtask

    task automatic preload(input bit b, input logic [4:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        if (b) begin pre_b = 1'b1; ref_b[a] = d; end
        else   begin pre_a = 1'b1; ref_a[a] = d; end
        @(posedge clk); #1;
        pre_a = 1'b0;
        pre_b = 1'b0;
    endtask

    // Issue one request, poke the opposite request and record_in mid-operation,
    // then measure strobe latency and busy duration.
    task automatic op(input bit b, input bit st, input bit ld, input int exp_lat, input string tag);
        int n, bc;
        logic seen;
        logic [47:0] mv0;
        sel = b;
        if (b) begin st_b = st; ld_b = ld; end else begin st_a = st; ld_a = ld; end
        @(posedge clk); #1;
        {st_a, ld_a, st_b, ld_b} = '0;
        mv0  = mv_s;
        n    = 0;
        bc   = int'(busy_s);
        seen = 1'b0;
        while (!seen && n < 30) begin
            if (n == 2) begin
                rec = ~rec;
                if (b) begin st_b = !st; ld_b = st; end else begin st_a = !st; ld_a = st; end
            end
            @(posedge clk); #1;
            {st_a, ld_a, st_b, ld_b} = '0;
            n++;
            bc += int'(busy_s);
            seen = lr_s | sd_s;
            if (!st && n == exp_lat - 1) chk({tag, "_no_partial"}, 64'(mv_s), 64'(mv0));
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_lat + 1));
        @(posedge clk); #1;
        chk({tag, "_strobe_once"}, 64'(lr_s | sd_s), 64'd0);
        chk({tag, "_busy_low"}, 64'(busy_s), 64'd0);
    endtask

    always @(negedge clk) begin
        if (wren_a) begin
            chk("a_write_expected", 64'(wq_a.size() != 0), 64'd1);
            if (wq_a.size() != 0) begin
                wa = wq_a.pop_front();
                chk("a_wr_addr", 64'(addr_a), 64'(wa.a));
                chk("a_wr_data", 64'(data_a), 64'(wa.d));
                ref_a[wa.a] = wa.d;
            end
        end
        if (lr_a || sd_a) begin
            chk("a_strobe_excl", 64'(lr_a & sd_a), 64'd0);
            chk("a_event_expected", 64'(eq_a.size() != 0), 64'd1);
            if (eq_a.size() != 0) begin
                ea = eq_a.pop_front();
                chk("a_kind", 64'(sd_a), 64'(ea.st));
                chk("a_mv", 64'(mv_a), 64'(ea.mv));
            end
        end
    end

    always @(negedge clk) begin
        if (wren_b) begin
            chk("b_write_expected", 64'(wq_b.size() != 0), 64'd1);
            if (wq_b.size() != 0) begin
                wb = wq_b.pop_front();
                chk("b_wr_addr", 64'(addr_b), 64'(wb.a));
                chk("b_wr_data", 64'(data_b), 64'(wb.d));
                ref_b[wb.a] = wb.d;
            end
        end
        if (lr_b || sd_b) begin
            chk("b_strobe_excl", 64'(lr_b & sd_b), 64'd0);
            chk("b_event_expected", 64'(eq_b.size() != 0), 64'd1);
            if (eq_b.size() != 0) begin
                eb = eq_b.pop_front();
                chk("b_kind", 64'(sd_b), 64'(eb.st));
                chk("b_mv", 64'(mv_b), 64'(eb.mv));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        {ld_a, st_a, ld_b, st_b} = '0;
        rec      = '0;
        sel      = 1'b0;
        pre_a    = 1'b0;
        pre_b    = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            preload(1'b0, 5'(k), 8'(17 * (k + 1)));
            preload(1'b1, 5'(30 + k), 8'(17 * (k + 1)));
        end
        chk("a_rst_mv", 64'(mv_a), 64'd0);
        chk("a_rst_busy", 64'(busy_a), 64'd0);
        chk("a_rst_lr", 64'(lr_a), 64'd0);
        chk("a_rst_sd", 64'(sd_a), 64'd0);
        chk("a_rst_wren", 64'(wren_a), 64'd0);
        chk("a_rst_addr", 64'(addr_a), 64'd0);
        chk("a_rst_data", 64'(data_a), 64'd0);
        chk("b_rst_mv", 64'(mv_b), 64'd0);
        chk("b_rst_busy", 64'(busy_b), 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        push_load(1'b0);
        op(1'b0, 1'b0, 1'b1, 8, "a_load");
        rec = 48'h0A0B0C0D0E0F;
        push_store(1'b0, rec);
        op(1'b0, 1'b1, 1'b0, 6, "a_store");
        push_load(1'b0);
        op(1'b0, 1'b0, 1'b1, 8, "a_reload");
        rec = 48'h123456789ABC;
        push_store(1'b0, rec);
        op(1'b0, 1'b1, 1'b1, 6, "a_tie");

        push_load(1'b1);
        op(1'b1, 1'b0, 1'b1, 9, "b_load");
        rec = 48'h0A0B0C0D0E0F;
        push_store(1'b1, rec);
        op(1'b1, 1'b1, 1'b0, 6, "b_store");
        push_load(1'b1);
        op(1'b1, 1'b0, 1'b1, 9, "b_reload");

        sel = 1'b0;
        rec = 48'hF1F2F3F4F5F6;
        push_store(1'b0, rec);
        st_a = 1'b1;
        @(posedge clk); #1;
        st_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("a_beat3_wren", 64'(wren_a), 64'd1);
        chk("a_beat3_addr", 64'(addr_a), 64'd3);
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("a_abort_wren", 64'(wren_a), 64'd0);
        chk("a_abort_busy", 64'(busy_a), 64'd0);
        chk("a_abort_mv", 64'(mv_a), 64'd0);
        chk("a_abort_addr", 64'(addr_a), 64'd0);
        chk("a_abort_done", 64'(sd_a), 64'd0);
        chk("a_abort_pending_writes", 64'(wq_a.size()), 64'd2);
        wq_a.delete();
        eq_a.delete();
        resetn = 1'b1;
        @(posedge clk); #1;
        push_load(1'b0);
        op(1'b0, 1'b0, 1'b1, 8, "a_post_reset");

        chk("a_events_left", 64'(eq_a.size()), 64'd0);
        chk("a_writes_left", 64'(wq_a.size()), 64'd0);
        chk("b_events_left", 64'(eq_b.size()), 64'd0);
        chk("b_writes_left", 64'(wq_b.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
